// File: rtl/msg_router.sv
// Serial message router: start bit, address, length, then payload bits
// fanned out to one output line per address (optionally broadcast).
module msg_router #(
  parameter int ADDR_W   = 6,
  parameter int SIZE_W   = 6,
  parameter bit BCAST_EN = 1'b1,
  localparam int N_OUT   = 2**ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serIn,
  output logic [N_OUT-1:0]  L,
  output logic              dvalid,
  output logic [ADDR_W-1:0] addr_q,
  output logic              busy,
  output logic              done
);

  localparam int MAXW = (ADDR_W > SIZE_W) ? ADDR_W : SIZE_W;
  localparam int CW   = $clog2(MAXW) + 1;

  typedef enum logic [1:0] {IDLE, ADDR, SIZE, DATA} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       bcnt_q, bcnt_d;
  logic [ADDR_W-1:0]   ash_q, ash_d, addr_d;
  logic [SIZE_W-1:0]   len_q, len_d;
  logic [N_OUT-1:0]    l_q, l_d;
  logic                dv_q, dv_d;
  logic                done_q, done_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      bcnt_q  <= '0;
      ash_q   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      l_q     <= '0;
      dv_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      ash_q   <= ash_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      l_q     <= l_d;
      dv_q    <= dv_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    ash_d   = ash_q;
    addr_d  = addr_q;
    len_d   = len_q;
    l_d     = '0;
    dv_d    = 1'b0;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (serIn) begin
          state_d = ADDR;
          bcnt_d  = '0;
          ash_d   = '0;
        end
      end
      ADDR: begin
        ash_d  = (ash_q << 1) | ADDR_W'(serIn);
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == CW'(ADDR_W - 1)) begin
          state_d = SIZE;
          addr_d  = ash_d;
          bcnt_d  = '0;
          len_d   = '0;
        end
      end
      SIZE: begin
        len_d  = (len_q << 1) | SIZE_W'(serIn);
        bcnt_d = bcnt_q + 1'b1;
        if (bcnt_q == CW'(SIZE_W - 1)) begin
          bcnt_d = '0;
          if (len_d == '0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        dv_d = 1'b1;
        if (BCAST_EN && (&addr_q)) begin
          l_d = {N_OUT{serIn}};
        end else begin
          l_d[addr_q] = serIn;
        end
        // saturate at zero; the exit test below catches the last bit
        if (len_q != '0) begin
          len_d = len_q - 1'b1;
        end
        if (len_q <= SIZE_W'(1)) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign L      = l_q;
  assign dvalid = dv_q;
  assign done   = done_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_msg_router.sv
// Directed bench for msg_router: broadcast and non-broadcast builds
// driven by the same serial stream.
module tb_msg_router;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        serIn = 1'b0;
  logic [63:0] L, L_nb;
  logic        dvalid, dvalid_nb;
  logic [5:0]  addr_q, addr_q_nb;
  logic        busy, busy_nb;
  logic        done, done_nb;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  msg_router dut (
    .clk    (clk),
    .rst    (rst),
    .serIn  (serIn),
    .L      (L),
    .dvalid (dvalid),
    .addr_q (addr_q),
    .busy   (busy),
    .done   (done)
  );

  msg_router #(.BCAST_EN(1'b0)) dut_nb (
    .clk    (clk),
    .rst    (rst),
    .serIn  (serIn),
    .L      (L_nb),
    .dvalid (dvalid_nb),
    .addr_q (addr_q_nb),
    .busy   (busy_nb),
    .done   (done_nb)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s got %h exp %h", tag, obs, exp);
  endtask

  task automatic tick(input logic b);
    serIn = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_hdr(input logic [5:0] a,
                          input logic [5:0] s);
    tick(1'b1);
    for (int i = 5; i >= 0; i--) tick(a[i]);
    for (int i = 5; i >= 0; i--) tick(s[i]);
  endtask

  initial begin
    int dv_cnt;
    int dn_cnt;
    logic any;

    tick(1'b0);
    tick(1'b1);
    chk("rst_L", L, 64'h0);
    chk("rst_dvalid", dvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", addr_q, 0);
    rst = 1'b0;
    tick(1'b0);

    send_hdr(6'd6, 6'd3);
    chk("m1_busy", busy, 1);
    tick(1'b1);
    chk("m1_b0_L", L, 64'h40);
    chk("m1_b0_dv", dvalid, 1);
    chk("m1_b0_done", done, 0);
    chk("m1_addr", addr_q, 6);
    tick(1'b0);
    chk("m1_b1_L", L, 64'h0);
    chk("m1_b1_dv", dvalid, 1);
    tick(1'b1);
    chk("m1_b2_L", L, 64'h40);
    chk("m1_b2_done", done, 1);
    chk("m1_b2_busy", busy, 0);
    tick(1'b0);
    chk("m1_end_dv", dvalid, 0);
    chk("m1_end_done", done, 0);
    chk("m1_end_L", L, 64'h0);

    send_hdr(6'd63, 6'd2);
    tick(1'b1);
    chk("bc0_L", L, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nb0_L", L_nb, 64'h8000_0000_0000_0000);
    tick(1'b1);
    chk("bc1_L", L, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("nb1_L", L_nb, 64'h8000_0000_0000_0000);
    chk("bc1_done", done, 1);
    tick(1'b0);
    chk("bc_end_L", L, 64'h0);
    chk("nb_end_L", L_nb, 64'h0);

    send_hdr(6'd9, 6'd0);
    chk("z_done", done, 1);
    chk("z_busy", busy, 0);
    chk("z_dv", dvalid, 0);
    chk("z_addr", addr_q, 9);
    tick(1'b0);
    chk("z_done2", done, 0);

    send_hdr(6'd2, 6'd1);
    tick(1'b1);
    chk("bb0_L", L, 64'h4);
    chk("bb0_done", done, 1);
    send_hdr(6'd5, 6'd1);
    chk("bb1_busy", busy, 1);
    tick(1'b1);
    chk("bb1_L", L, 64'h20);
    chk("bb1_done", done, 1);
    chk("bb1_addr", addr_q, 5);
    tick(1'b0);

    send_hdr(6'd3, 6'd5);
    tick(1'b1);
    tick(1'b1);
    chk("ab_dv", dvalid, 1);
    rst = 1'b1;
    tick(1'b1);
    chk("ab_L", L, 64'h0);
    chk("ab_dv0", dvalid, 0);
    chk("ab_busy", busy, 0);
    chk("ab_done", done, 0);
    rst = 1'b0;
    any = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0);
      any = any | dvalid | done | busy;
    end
    chk("ab_quiet", any, 0);
    send_hdr(6'd1, 6'd1);
    tick(1'b1);
    chk("ab_new_L", L, 64'h2);
    chk("ab_new_done", done, 1);

    dv_cnt = 0;
    dn_cnt = 0;
    send_hdr(6'd0, 6'd63);
    for (int i = 0; i < 63; i++) begin
      tick(i[0]);
      dv_cnt += int'(dvalid);
      dn_cnt += int'(done);
    end
    chk("max_dv", 64'(dv_cnt), 63);
    chk("max_dn", 64'(dn_cnt), 1);
    chk("max_last_done", done, 1);
    chk("max_last_L", L, 64'h0);
    tick(1'b0);
    chk("max_end_dv", dvalid, 0);

    any = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0);
      any = any | busy | dvalid | done;
    end
    chk("idle_quiet", any, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
